instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

- Front end of the RISC-V core: issues instruction-memory reads from a program counter and buffers returned words in order.
- Presents buffered words to the decode stage, where the opcode and instruction bus feed the immediate generator and control unit.
- Supports decode back-pressure, branch/jump redirects from execute, and discarding of in-flight responses made stale by a redirect.

## Interface
- RESET_PC, 32'h0040_0000, PC loaded on reset.
- DEPTH, 4, instruction buffer entries; power of two, ≥2.
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_req_o  output  1  read request valid.
- imem_addr_o  output  32  request address; word-aligned.
- imem_ready_i  input  1  memory accepts request this cycle.
- imem_rvalid_i  input  1  read data valid; responses return in request order.
- imem_rdata_i  input  32  read data.
- redirect_i  input  1  branch/jump taken; flush and refetch.
- redirect_pc_i  input  32  target PC; bits [1:0] forced to 0.
- ready_i  input  1  decode accepts the head instruction.
- valid_o  output  1  head instruction valid.
- Instruction_bus_o  output  32  head instruction word.
- op_o  output  7  Instruction_bus_o[6:0].
- pc_o  output  32  PC of the head instruction.
- illegal_o  output  1  head opcode unsupported; see Configuration.

## Operation
- State:
  - pc_q: next fetch PC.
  - resp_pc_q: PC of the next kept response.
  - outstanding_q: accepted requests not yet returned.
  - discard_q: responses to drop.
  - FIFO of {pc, instr}, DEPTH entries.
- Issue:
  - imem_req_o = !redirect_i && (fifo_count + outstanding_q < DEPTH); imem_addr_o = pc_q.
  - On req && ready: pc_q += 4 (wraps modulo 2^32) and outstanding_q increments.
- Response:
  - On rvalid: outstanding_q decrements.
  - If discard_q > 0: discard_q decrements and the word is dropped.
  - Otherwise push {resp_pc_q, rdata} and resp_pc_q += 4.
  - rvalid while outstanding_q == 0 is ignored.
- Pop:
  - valid_o = FIFO non-empty; the head is consumed on valid_o && ready_i.
  - When empty: Instruction_bus_o = 32'h0000_0013 (NOP), op_o = 7'h13, pc_o = 0, illegal_o = 0.
- Redirect (highest priority):
  - pc_q and resp_pc_q ← redirect_pc_i & ~3.
  - FIFO flushed; any same-cycle pop or push is discarded.
  - discard_q ← outstanding count after this cycle's accept/return. Same-cycle accepts count; same-cycle returns are dropped.
  - No request is issued in the redirect cycle.
- Simultaneous push and pop on a full FIFO cannot occur, because credit gating keeps room for every outstanding response.

## Timing
- Reset values: pc_q = RESET_PC; counters 0; FIFO empty; imem_req_o = 0 while reset is low; valid_o = 0.
- The first request is issued in the first cycle after reset deasserts.
- Response at cycle R: valid_o at R+1. No bypass from imem_rdata_i to outputs.
- Redirect at cycle N: request to the target at N+1. With 1-cycle memory, the instruction is valid at N+3.
- Steady state with single-cycle memory and ready_i held high: one instruction per cycle.
- Reset asserted mid-operation clears all state immediately; late responses after reset are ignored because outstanding_q = 0.

## Configuration
- FETCH_ILLEGAL_CHECK_EN defined: illegal_o = valid_o && op_o ∉ {7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6f}.
- Not defined: illegal_o tied to 0 and no decode logic is synthesized.

## Structure
- Shared package holds:
  - opcode constants (OP_LOAD 7'h03, OP_IMM 7'h13, OP_AUIPC 7'h17, OP_STORE 7'h23, OP_REG 7'h33, OP_LUI 7'h37, OP_BRANCH 7'h63, OP_JALR 7'h67, OP_JAL 7'h6f);
  - the NOP constant 32'h0000_0013;
  - the RESET_PC default.
- One sub-module, fetch_fifo: synchronous DEPTH-entry FIFO with flush, count output, 64-bit {pc, instr} entries.
- Issue, credit and discard logic live in the top.

## Test plan
- Reset, single-cycle memory, ready_i = 1 → addresses 0x00400000, 0x00400004, …; pc_o and instruction stream match one per cycle.
- ready_i = 0 for 10 cycles → imem_req_o drops once fifo_count + outstanding = 4; no word lost or duplicated after release.
- 3-cycle memory latency, redirect to 0x00400103 with 2 outstanding → next address 0x00400100, 2 responses dropped, first valid pc_o = 0x00400100.
- Redirect in the same cycle as rvalid and pop → returning word dropped, FIFO empty next cycle, outputs show the NOP.
- pc_q = 0xFFFFFFFC → next request address 0x00000000.
- FETCH_ILLEGAL_CHECK_EN defined, memory returns 32'h0000_007F → illegal_o = 1 with valid_o; 32'h0000_0013 → illegal_o = 0; macro undefined → always 0.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared opcodes, NOP, reset PC and entry type for the fetch unit
package instruction_fetch_unit_pkg;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6f;

  // addi x0, x0, 0 - shown to decode whenever the buffer is empty
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // One buffered fetch: the word and the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // True for the base-ISA major opcodes the core decodes
  function automatic logic op_is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// rtl/instruction_fetch_unit_fetch_fifo.sv - DEPTH-entry in-order instruction buffer with flush and count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer or a pop from an empty one is ignored rather than corrupting state
  assign do_push   = push && (count != (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  // Storage array; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush wins over any same-cycle push or pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC-driven instruction fetch with credit-gated issue, redirect and stale-response discard (option: FETCH_ILLEGAL_CHECK_EN)
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] Instruction_bus_o,
  output logic [6:0]  op_o,
  output logic [31:0] pc_o,
  output logic        illegal_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q;
  logic [31:0]   resp_pc_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] outstanding_d;
  logic [CW-1:0] discard_q;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [31:0]   redirect_tgt;
  logic          credit_ok;
  logic          accept;
  logic          ret;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign redirect_tgt = redirect_pc_i & ~32'd3;

  // Every request in flight owns a buffer slot, so a response can always be stored
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);

  // Reset gating keeps the request line quiet while reset is held low
  assign imem_req_o  = reset && !redirect_i && credit_ok;
  assign imem_addr_o = pc_q;
  assign accept      = imem_req_o && imem_ready_i;

  // A response with nothing outstanding is a leftover from before reset
  assign ret  = imem_rvalid_i && (outstanding_q != '0);
  assign push = ret && (discard_q == '0) && !redirect_i;
  assign pop  = !fifo_empty && ready_i && !redirect_i;

  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata_i};

  // Outstanding count after this cycle's accept and return
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept) outstanding_d = outstanding_d + CW'(1);
    if (ret)    outstanding_d = outstanding_d - CW'(1);
  end

  // Fetch PC, response PC, credit and discard bookkeeping; redirect overrides everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else if (redirect_i) begin
      pc_q          <= redirect_tgt;
      resp_pc_q     <= redirect_tgt;
      outstanding_q <= outstanding_d;
      discard_q     <= outstanding_d;
    end else begin
      outstanding_q <= outstanding_d;
      if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
      if (ret) begin
        if (discard_q != '0) begin
          discard_q <= discard_q - CW'(1);
        end else begin
          resp_pc_q <= resp_pc_q + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head presentation; an empty buffer shows a NOP at PC 0
  always_comb begin
    valid_o           = !fifo_empty;
    Instruction_bus_o = NOP_INSN;
    pc_o              = 32'd0;
    if (!fifo_empty) begin
      Instruction_bus_o = head.instr;
      pc_o              = head.pc;
    end
  end

  assign op_o = Instruction_bus_o[6:0];

`ifdef FETCH_ILLEGAL_CHECK_EN
  assign illegal_o = valid_o && !op_is_legal(op_o);
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed table and sequence checks for instruction_fetch_unit
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

`ifdef FETCH_ILLEGAL_CHECK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] Instruction_bus_o;
  logic [6:0]  op_o;
  logic [31:0] pc_o;
  logic        illegal_o;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ready_i      (imem_ready_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .ready_i           (ready_i),
    .valid_o           (valid_o),
    .Instruction_bus_o (Instruction_bus_o),
    .op_o              (op_o),
    .pc_o              (pc_o),
    .illegal_o         (illegal_o)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  pend_t q[$];
  vec_t  vecs[21];
  int    cyc;
  int    lat;
  bit    ill_mode;
  int    checks;
  int    errors;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (ill_mode) return a[2] ? 32'h0000_007F : 32'h0000_0013;
    return {a[26:2], 7'h13};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic exp_valid, input logic [31:0] exp_pc);
    logic [31:0] exp_word;
    exp_word = exp_valid ? word_of(exp_pc) : NOP_INSN;
    chk({nm, "_valid"}, {31'd0, valid_o}, {31'd0, exp_valid});
    chk({nm, "_pc"}, pc_o, exp_valid ? exp_pc : 32'd0);
    chk({nm, "_instr"}, Instruction_bus_o, exp_word);
    chk({nm, "_op"}, {25'd0, op_o}, {25'd0, exp_word[6:0]});
  endtask

  // End the current cycle (record accepted request), advance to posedge+1 and drive the response
  task automatic tick();
    @(negedge clk);
    if (imem_req_o && imem_ready_i) q.push_back('{imem_addr_o, cyc + lat});
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = word_of(q[0].addr);
      void'(q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset(input int l);
    reset         = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    ready_i       = 1'b1;
    imem_ready_i  = 1'b1;
    ill_mode      = 1'b0;
    lat           = l;
    q.delete();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    tick();
    tick();
    #1;
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_o}, 32'd0);
    chk_head("rst", 1'b0, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    lat    = 1;

    // Streaming then 10 cycles of back-pressure, 1-cycle memory
    vecs[0]  = '{1'b1, 1'b1, BASE + 32'h00, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, BASE + 32'h04, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b1, BASE + 32'h08, 1'b1, BASE + 32'h00};
    vecs[3]  = '{1'b1, 1'b1, BASE + 32'h0C, 1'b1, BASE + 32'h04};
    vecs[4]  = '{1'b1, 1'b1, BASE + 32'h10, 1'b1, BASE + 32'h08};
    vecs[5]  = '{1'b1, 1'b1, BASE + 32'h14, 1'b1, BASE + 32'h0C};
    vecs[6]  = '{1'b0, 1'b1, BASE + 32'h18, 1'b1, BASE + 32'h10};
    vecs[7]  = '{1'b0, 1'b1, BASE + 32'h1C, 1'b1, BASE + 32'h10};
    for (int i = 8; i <= 15; i++) vecs[i] = '{1'b0, 1'b0, 32'h0, 1'b1, BASE + 32'h10};
    vecs[16] = '{1'b1, 1'b0, 32'h0, 1'b1, BASE + 32'h10};
    vecs[17] = '{1'b1, 1'b1, BASE + 32'h20, 1'b1, BASE + 32'h14};
    vecs[18] = '{1'b1, 1'b1, BASE + 32'h24, 1'b1, BASE + 32'h18};
    vecs[19] = '{1'b1, 1'b1, BASE + 32'h28, 1'b1, BASE + 32'h1C};
    vecs[20] = '{1'b1, 1'b1, BASE + 32'h2C, 1'b1, BASE + 32'h20};

    do_reset(1);
    for (int i = 0; i < 21; i++) begin
      if (i != 0) tick();
      ready_i = vecs[i].ready;
      #1;
      chk($sformatf("tbl%0d_req", i), {31'd0, imem_req_o}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req) chk($sformatf("tbl%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
      chk_head($sformatf("tbl%0d", i), vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // 3-cycle memory: redirect with two requests in flight
    do_reset(3);
    #1;
    tick();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0103;
    #1;
    chk("rd3_no_req", {31'd0, imem_req_o}, 32'd0);
    tick();
    redirect_i = 1'b0;
    #1;
    chk("rd3_req", {31'd0, imem_req_o}, 32'd1);
    chk("rd3_addr", imem_addr_o, 32'h0040_0100);
    chk_head("rd3_c3", 1'b0, 32'd0);
    for (int i = 4; i <= 6; i++) begin
      tick();
      #1;
      chk($sformatf("rd3_c%0d_valid", i), {31'd0, valid_o}, 32'd0);
    end
    tick();
    #1;
    chk_head("rd3_first", 1'b1, 32'h0040_0100);
    tick();
    #1;
    chk_head("rd3_second", 1'b1, 32'h0040_0104);

    // Redirect coinciding with a response and a pop
    do_reset(1);
    #1;
    tick();
    tick();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0200;
    #1;
    chk("rdp_rvalid", {31'd0, imem_rvalid_i}, 32'd1);
    chk("rdp_no_req", {31'd0, imem_req_o}, 32'd0);
    chk_head("rdp_c3", 1'b1, BASE + 32'h04);
    tick();
    redirect_i = 1'b0;
    #1;
    chk_head("rdp_nop", 1'b0, 32'd0);
    chk("rdp_addr", imem_addr_o, 32'h0040_0200);
    tick();
    #1;
    chk("rdp_c5_valid", {31'd0, valid_o}, 32'd0);
    tick();
    #1;
    chk_head("rdp_n3", 1'b1, 32'h0040_0200);

    // PC wrap past 0xFFFFFFFC
    do_reset(1);
    #1;
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    #1;
    chk("wrap_addr1", imem_addr_o, 32'h0000_0000);
    chk("wrap_c3_valid", {31'd0, valid_o}, 32'd0);
    tick();
    #1;
    chk_head("wrap_head0", 1'b1, 32'hFFFF_FFFC);
    tick();
    #1;
    chk_head("wrap_head1", 1'b1, 32'h0000_0000);

    // Illegal opcode flag: 0x13 then 0x7F
    do_reset(1);
    ill_mode = 1'b1;
    #1;
    tick();
    #1;
    chk("ill_empty", {31'd0, illegal_o}, 32'd0);
    tick();
    #1;
    chk_head("ill_nop", 1'b1, BASE);
    chk("ill_legal", {31'd0, illegal_o}, 32'd0);
    tick();
    #1;
    chk_head("ill_7f", 1'b1, BASE + 32'h04);
    chk("ill_flag", {31'd0, illegal_o}, {31'd0, ILL_EN});

    // Reset mid-flight; the stale response arrives with nothing outstanding
    do_reset(3);
    #1;
    tick();
    reset = 1'b0;
    #1;
    chk("mrst_req", {31'd0, imem_req_o}, 32'd0);
    chk("mrst_valid", {31'd0, valid_o}, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mrst_stale_rvalid", {31'd0, imem_rvalid_i}, 32'd1);
    chk("mrst_addr", imem_addr_o, BASE);
    for (int i = 4; i <= 6; i++) begin
      tick();
      #1;
      chk($sformatf("mrst_c%0d_valid", i), {31'd0, valid_o}, 32'd0);
    end
    tick();
    #1;
    chk_head("mrst_first", 1'b1, BASE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
